// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed common-anode 7-segment scanner with tear-free
// load handshake, per-digit decimal points, leading-zero blanking and 16-level PWM.
// Ports: clk/reset (async, active-high); value/dp_in/value_valid/value_ready load
// handshake; lz_blank, brightness controls; an/seg/dp active-low pins; frame_start
// pulse on display update. Optional SEG7_BLINK_EN adds blink_mask and BLINK_FRAMES.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SUB_CYCLES = 7696
`ifdef SEG7_BLINK_EN
  , parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic [NUM_DIGITS-1:0]   dp_in,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  input  logic                    lz_blank,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int SW = SUB_CYCLES > 1 ? $clog2(SUB_CYCLES) : 1;

  function automatic logic [6:0] f_decode(input logic [3:0] n);
    case (n)
      4'h0: f_decode = 7'b1000000;
      4'h1: f_decode = 7'b1111001;
      4'h2: f_decode = 7'b0100100;
      4'h3: f_decode = 7'b0110000;
      4'h4: f_decode = 7'b0011001;
      4'h5: f_decode = 7'b0010010;
      4'h6: f_decode = 7'b0000010;
      4'h7: f_decode = 7'b1111000;
      4'h8: f_decode = 7'b0000000;
      4'h9: f_decode = 7'b0010000;
      4'hA: f_decode = 7'b0001000;
      4'hB: f_decode = 7'b0000011;
      4'hC: f_decode = 7'b1000110;
      4'hD: f_decode = 7'b0100001;
      4'hE: f_decode = 7'b0000110;
      default: f_decode = 7'b0001110;
    endcase
  endfunction

  logic [SW-1:0]           r_sub_cnt;
  logic [3:0]              r_phase, r_bright_q;
  logic [IW-1:0]           r_idx;
  logic                    r_init, r_pend_full;
  logic [4*NUM_DIGITS-1:0] r_pend_val, r_disp;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_disp_dp, r_an, w_keep;
  logic [6:0]              r_seg;
  logic                    r_dp, r_frame_start;
  logic                    w_sub_tick, w_slot_end, w_frame_end, w_accept, w_load;
  logic                    w_blink, w_blank, w_lit;
  logic [3:0]              w_bright, w_nib;

  assign w_sub_tick  = r_sub_cnt == SW'(SUB_CYCLES - 1);
  assign w_slot_end  = w_sub_tick && r_phase == 4'd15;
  assign w_frame_end = w_slot_end && r_idx == IW'(NUM_DIGITS - 1);
  assign w_accept    = value_valid && !r_pend_full;
  assign w_load      = w_frame_end && r_pend_full;
  assign value_ready = !r_pend_full;
  // the first slot after reset has had no slot_end to latch brightness yet
  assign w_bright    = r_init ? brightness : r_bright_q;
  assign w_nib       = r_disp[4*r_idx +: 4];

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sub_cnt  <= '0;
      r_phase    <= '0;
      r_idx      <= '0;
      r_init     <= 1'b1;
      r_bright_q <= '0;
    end else begin
      r_sub_cnt <= w_sub_tick ? '0 : r_sub_cnt + 1'b1;
      r_init    <= 1'b0;
      if (w_sub_tick) r_phase <= r_phase + 1'b1;
      if (w_slot_end) r_idx <= w_frame_end ? '0 : r_idx + 1'b1;
      if (r_init || w_slot_end) r_bright_q <= brightness;
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_pend_full <= 1'b0;
      r_pend_val  <= '0;
      r_pend_dp   <= '0;
      r_disp      <= '0;
      r_disp_dp   <= '0;
    end else if (w_load) begin
      r_disp      <= r_pend_val;
      r_disp_dp   <= r_pend_dp;
      r_pend_full <= 1'b0;
    end else if (w_accept) begin
      r_pend_val  <= value;
      r_pend_dp   <= dp_in;
      r_pend_full <= 1'b1;
    end

`ifdef SEG7_BLINK_EN
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [NUM_DIGITS-1:0] r_pend_blink, r_disp_blink;
  logic [FW-1:0]         r_fcnt;
  logic                  r_blink_phase;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_pend_blink  <= '0;
      r_disp_blink  <= '0;
      r_fcnt        <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      if (w_load) r_disp_blink <= r_pend_blink;
      else if (w_accept) r_pend_blink <= blink_mask;
      if (w_frame_end) begin
        r_fcnt <= r_fcnt == FW'(BLINK_FRAMES - 1) ? '0 : r_fcnt + 1'b1;
        if (r_fcnt == FW'(BLINK_FRAMES - 1)) r_blink_phase <= !r_blink_phase;
      end
    end
  assign w_blink = r_blink_phase && r_disp_blink[r_idx];
`else
  assign w_blink = 1'b0;
`endif

  // w_keep[i]: some nibble or dp at position i or above is significant
  always_comb begin
    logic v_acc;
    v_acc  = 1'b0;
    w_keep = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_acc     = v_acc | (|r_disp[4*i +: 4]) | r_disp_dp[i];
      w_keep[i] = v_acc;
    end
  end

  assign w_blank = (lz_blank && r_idx != '0 && !w_keep[r_idx]) || w_blink;
  assign w_lit   = r_phase <= w_bright && !w_blank;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_an          <= '1;
      r_seg         <= 7'h7F;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_an          <= w_lit ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      r_seg         <= w_lit ? f_decode(w_nib) : 7'h7F;
      r_dp          <= w_lit ? ~r_disp_dp[r_idx] : 1'b1;
      r_frame_start <= w_frame_end;
    end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed scoreboard bench for seg7_scan_ctrl (4 digits, 2-cycle sub-phase).
module tb_seg7_scan_ctrl;
  localparam int N = 4;
  logic          clk = 1'b0, reset = 1'b0;
  logic [4*N-1:0] value = '0;
  logic          value_valid = 1'b0, value_ready;
  logic [N-1:0]  dp_in = '0, an;
  logic          lz_blank = 1'b0, dp, frame_start;
  logic [3:0]    brightness = 4'd15;
  logic [6:0]    seg;
`ifdef SEG7_BLINK_EN
  logic [N-1:0]  blink_mask = '0;
`endif
  int n_pass = 0, n_total = 0;
  int exp_q[$];

  seg7_scan_ctrl #(.NUM_DIGITS(N), .SUB_CYCLES(2)
`ifdef SEG7_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .value_ready(value_ready), .dp_in(dp_in),
`ifdef SEG7_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .lz_blank(lz_blank), .brightness(brightness), .an(an), .seg(seg), .dp(dp),
    .frame_start(frame_start));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int ex(input logic [3:0] a, input logic [6:0] s, input logic p);
    return int'({a, s, p});
  endfunction

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    int t;
    t = 0;
    value = v; dp_in = d; value_valid = 1'b1;
    while (!value_ready && t < 1000) begin @(negedge clk); t++; end
    chk("load_wait", t < 1000, 1);
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    @(negedge clk);
    while (!frame_start && n < 2000) begin @(negedge clk); n++; end
    chk("frame_wait", n < 2000, 1);
  endtask

  task automatic check_digits(input int skip);
    int e;
    for (int d = 0; d < N; d++) begin
      repeat (d == 0 ? 16 - skip : 32) @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("d%0d_an", d), an, e[11:8]);
      chk($sformatf("d%0d_seg", d), seg, e[7:1]);
      chk($sformatf("d%0d_dp", d), dp, e[0]);
    end
  endtask

  task automatic count_slots(input int n, input int chg);
    int c;
    for (int d = 0; d < n; d++) begin
      c = 0;
      for (int k = 1; k <= 32; k++) begin
        @(negedge clk);
        if (d == 0 && k == chg) brightness = 4'd15;
        if (an !== 4'hF) c++;
      end
      chk($sformatf("lit_slot%0d", d), c, exp_q.pop_front());
    end
  endtask

  initial begin
    int n;
    #1 reset = 1'b1;
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_fs", frame_start, 0);
    chk("rst_ready", value_ready, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // basic scan of 1A2C
    exp_q.push_back(ex(4'b1110, 7'b1000110, 1));
    exp_q.push_back(ex(4'b1101, 7'b0100100, 1));
    exp_q.push_back(ex(4'b1011, 7'b0001000, 1));
    exp_q.push_back(ex(4'b0111, 7'b1111001, 1));
    load(16'h1A2C, 4'b0000);
    chk("ready_low_after_load", value_ready, 0);
    wait_frame(n);
    check_digits(0);
    wait_frame(n);
    wait_frame(n);
    chk("frame_period", n + 1, 128);
    @(negedge clk);
    chk("fs_one_cycle", frame_start, 0);

    // back-to-back offers: second waits for the frame boundary
    load(16'h0001, 4'b0000);
    value = 16'h0002; value_valid = 1'b1;
    chk("ready_blocked", value_ready, 0);
    n = 0;
    while (!value_ready && n < 1000) begin @(negedge clk); n++; end
    chk("ready_wait", n < 1000, 1);
    chk("ready_with_fs", frame_start, 1);
    exp_q.push_back(ex(4'b1110, 7'b1111001, 1));
    exp_q.push_back(ex(4'b1101, 7'b1000000, 1));
    exp_q.push_back(ex(4'b1011, 7'b1000000, 1));
    exp_q.push_back(ex(4'b0111, 7'b1000000, 1));
    @(negedge clk);
    value_valid = 1'b0;
    chk("second_accepted", value_ready, 0);
    check_digits(1);
    exp_q.push_back(ex(4'b1110, 7'b0100100, 1));
    exp_q.push_back(ex(4'b1101, 7'b1000000, 1));
    exp_q.push_back(ex(4'b1011, 7'b1000000, 1));
    exp_q.push_back(ex(4'b0111, 7'b1000000, 1));
    wait_frame(n);
    check_digits(0);

    // leading-zero blanking, then a dp on the top digit defeats it
    lz_blank = 1'b1;
    load(16'h0030, 4'b0000);
    exp_q.push_back(ex(4'b1110, 7'b1000000, 1));
    exp_q.push_back(ex(4'b1101, 7'b0110000, 1));
    exp_q.push_back(ex(4'b1111, 7'h7F, 1));
    exp_q.push_back(ex(4'b1111, 7'h7F, 1));
    wait_frame(n);
    check_digits(0);
    load(16'h0030, 4'b1000);
    exp_q.push_back(ex(4'b1110, 7'b1000000, 1));
    exp_q.push_back(ex(4'b1101, 7'b0110000, 1));
    exp_q.push_back(ex(4'b1011, 7'b1000000, 1));
    exp_q.push_back(ex(4'b0111, 7'b1000000, 0));
    wait_frame(n);
    check_digits(0);

    // PWM duty: brightness 3 lights phases 0..3 = 8 of 32 cycles
    lz_blank = 1'b0;
    brightness = 4'd3;
    load(16'h1234, 4'b0000);
    wait_frame(n);
    repeat (4) exp_q.push_back(8);
    count_slots(N, -1);
    wait_frame(n);
    exp_q.push_back(8);
    repeat (3) exp_q.push_back(32);
    count_slots(N, 10);

    // reset mid-frame
    load(16'hBEEF, 4'b0000);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_an", an, 4'hF);
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_ready", value_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_an", an, 4'b1110);
    chk("restart_seg", seg, 7'b1000000);
    wait_frame(n);
    chk("restart_frame_len", n, 126);
    repeat (N) exp_q.push_back(0);
    for (int d = 0; d < N; d++) exp_q[d] = ex(~(4'b1 << d), 7'b1000000, 1);
    check_digits(0);

`ifdef SEG7_BLINK_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    blink_mask = 4'b0001;
    load(16'h1111, 4'b0000);
    for (int f = 1; f <= 5; f++) begin
      wait_frame(n);
      exp_q.push_back(((f / 2) % 2) ? 0 : 32);
      exp_q.push_back(32);
      count_slots(2, -1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
